// File: rtl/gauss_pass_sequencer_if.sv
// Control and RAM-address bus between the pass sequencer,
// the ping-pong matrix RAM and the systolic elimination chain.
interface gauss_pass_sequencer_if #(
  parameter int unsigned AW = 7
);
  logic          go;
  logic          busy;
  logic          done;
  logic          result_bank;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          arr_valid;
  logic          row_start;
  logic          row_finish;
  logic          first_pass;
  logic          pass_thru;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  modport master (
    input  go,
    output busy, done, result_bank,
    output rd_en, rd_addr,
    output arr_valid, row_start, row_finish, first_pass, pass_thru,
    output wr_en, wr_addr
  );

  modport slave (
    output go,
    input  busy, done, result_bank,
    input  rd_en, rd_addr,
    input  arr_valid, row_start, row_finish, first_pass, pass_thru,
    input  wr_en, wr_addr
  );
endinterface

// File: rtl/gauss_pass_sequencer.sv
// Runs ceil(N_R/DEPTH) elimination passes over a ping-pong RAM, streaming every row
// column-serially through the cell chain and writing the chain output to the other bank.
module gauss_pass_sequencer #(
  parameter int unsigned N_R      = 8,
  parameter int unsigned N_C      = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gauss_pass_sequencer_if.master bus
);
  localparam int unsigned RW        = $clog2(N_R);
  localparam int unsigned CW        = $clog2(N_C);
  localparam int unsigned AW        = 1 + RW + CW;
  localparam int unsigned NUM_PASS  = (N_R + DEPTH - 1) / DEPTH;
  localparam int unsigned PW        = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int unsigned WR_LAT    = RD_LAT + PIPE_LAT;
  localparam int unsigned DW        = $clog2(WR_LAT + 1);
  localparam int unsigned CTRL_W    = 5;
  localparam int unsigned B_VALID   = 4;
  localparam int unsigned B_RSTART  = 3;
  localparam int unsigned B_RFINISH = 2;
  localparam int unsigned B_FIRST   = 1;
  localparam int unsigned B_THRU    = 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pass_q, pass_d;
  logic                bank_q, bank_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                result_bank_q, result_bank_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [CTRL_W-1:0]   iss_q, iss_d;

  logic [CTRL_W-1:0]   ctrl_sr  [RD_LAT];
  logic [AW-1:0]       waddr_sr [WR_LAT];
  logic                wv_sr    [PIPE_LAT];
  logic [AW-1:0]       waddr_in_c;

  // State, counters and the issue-stage (RUN cycle) read strobe/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pass_q        <= '0;
      bank_q        <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      drain_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      result_bank_q <= 1'b0;
      rd_addr_q     <= '0;
      iss_q         <= '0;
    end else begin
      state_q       <= state_d;
      pass_q        <= pass_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      drain_q       <= drain_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      result_bank_q <= result_bank_d;
      rd_addr_q     <= rd_addr_d;
      iss_q         <= iss_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pass_d        = pass_q;
    bank_d        = bank_q;
    row_d         = row_q;
    col_d         = col_q;
    drain_d       = drain_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    result_bank_d = result_bank_q;
    rd_addr_d     = '0;
    iss_d         = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          pass_d  = '0;
          bank_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (col_q == CW'(N_C - 1)) begin
          col_d = '0;
          if (row_q == RW'(N_R - 1)) begin
            row_d   = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      // Hold off the next pass until the last write of this one has left the pipe
      S_DRAIN: begin
        if (drain_q == DW'(WR_LAT - 1)) begin
          if (pass_q == PW'(NUM_PASS - 1)) begin
            state_d = S_DONE;
          end else begin
            pass_d  = pass_q + 1'b1;
            bank_d  = ~bank_q;
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d        = 1'b0;
        done_d        = 1'b1;
        result_bank_d = ~bank_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RUN) begin
      rd_addr_d = {bank_d, row_d, col_d};
      iss_d     = {1'b1, col_d == '0, col_d == CW'(N_C - 1), pass_d == '0,
                   32'(row_d) < 32'(pass_d) * DEPTH};
    end
  end

  // Write address leaves the read stage already retargeted at the other bank
  assign waddr_in_c = iss_q[B_VALID] ? {~rd_addr_q[AW-1], rd_addr_q[AW-2:0]} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++)   ctrl_sr[i]  <= '0;
      for (int i = 0; i < WR_LAT; i++)   waddr_sr[i] <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wv_sr[i]    <= 1'b0;
    end else begin
      ctrl_sr[0]  <= iss_q;
      waddr_sr[0] <= waddr_in_c;
      wv_sr[0]    <= ctrl_sr[RD_LAT-1][B_VALID];
      for (int i = 1; i < RD_LAT; i++)   ctrl_sr[i]  <= ctrl_sr[i-1];
      for (int i = 1; i < WR_LAT; i++)   waddr_sr[i] <= waddr_sr[i-1];
      for (int i = 1; i < PIPE_LAT; i++) wv_sr[i]    <= wv_sr[i-1];
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_bank = result_bank_q;
  assign bus.rd_en       = iss_q[B_VALID];
  assign bus.rd_addr     = rd_addr_q;
  assign bus.arr_valid   = ctrl_sr[RD_LAT-1][B_VALID];
  assign bus.row_start   = ctrl_sr[RD_LAT-1][B_RSTART];
  assign bus.row_finish  = ctrl_sr[RD_LAT-1][B_RFINISH];
  assign bus.first_pass  = ctrl_sr[RD_LAT-1][B_FIRST];
  assign bus.pass_thru   = ctrl_sr[RD_LAT-1][B_THRU];
  assign bus.wr_en       = wv_sr[PIPE_LAT-1];
  assign bus.wr_addr     = waddr_sr[WR_LAT-1];
endmodule

// File: tb/tb_gauss_pass_sequencer.sv
// Scoreboard bench: an 8-row and a 6-row sequencer share go/rst; a run-level model
// schedules every expected read, chain-input word, write and done by cycle number.
module tb_gauss_pass_sequencer;
  localparam int AW    = 7;
  localparam int NC    = 8;
  localparam int DEPTH = 4;
  localparam int RDL   = 1;
  localparam int PL    = 4;
  localparam int NI    = 2;
  localparam int K_RD  = 0;
  localparam int K_AR  = 1;
  localparam int K_WR  = 2;
  localparam int K_DN  = 3;

  typedef struct packed {
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          arr_valid;
    logic          row_start;
    logic          row_finish;
    logic          first_pass;
    logic          pass_thru;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          result_bank;
  } obs_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  obs_t obs [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : u
    gauss_pass_sequencer_if #(.AW(AW)) bus ();
    assign bus.go = go;
    gauss_pass_sequencer #(
      .N_R(g == 0 ? 8 : 6), .N_C(NC), .DEPTH(DEPTH), .RD_LAT(RDL), .PIPE_LAT(PL)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign obs[g] = {bus.rd_en, bus.rd_addr, bus.arr_valid, bus.row_start, bus.row_finish,
                     bus.first_pass, bus.pass_thru, bus.wr_en, bus.wr_addr, bus.busy,
                     bus.done, bus.result_bank};
  end

  ev_t evq [NI][4][$];
  int  idle_at [NI] = '{0, 0};
  int  busy_lo [NI] = '{1, 1};
  int  busy_hi [NI] = '{0, 0};
  int  cyc        = 0;
  logic rst_prev  = 1'b1;
  bit  finish_req = 1'b0;
  int  total      = 0;
  int  bad        = 0;

  function automatic int nrows(input int i);
    return (i == 0) ? 8 : 6;
  endfunction

  task automatic fail(input string nm, input int i, input int got_c, input int got,
                      input int want_c, input int want);
    bad++;
    $display("FAIL %s dut%0d cyc=%0d got=%0h@%0d want=%0h@%0d", nm, i, cyc, got, got_c, want, want_c);
  endtask

  task automatic push_ev(input int i, input int kd, input int t, input int v);
    ev_t e;
    e.cyc = t;
    e.val = AW'(v);
    evq[i][kd].push_back(e);
  endtask

  // Accepted go in cycle k: whole run laid out pass by pass from the matrix shape
  task automatic schedule_run(input int i, input int k);
    int nr, np, per, t, rb, wb, fl;
    nr  = nrows(i);
    np  = (nr + DEPTH - 1) / DEPTH;
    per = nr * NC + RDL + PL;
    for (int p = 0; p < np; p++) begin
      rb = p % 2;
      wb = 1 - rb;
      for (int r = 0; r < nr; r++) begin
        for (int c = 0; c < NC; c++) begin
          t  = k + 1 + p * per + r * NC + c;
          fl = 8 * int'(c == 0) + 4 * int'(c == NC - 1) + 2 * int'(p == 0) + int'(r < p * DEPTH);
          push_ev(i, K_RD, t, rb * 64 + r * 8 + c);
          push_ev(i, K_AR, t + RDL, fl);
          push_ev(i, K_WR, t + RDL + PL, wb * 64 + r * 8 + c);
        end
      end
    end
    push_ev(i, K_DN, k + np * per + 2, 1 - ((np - 1) % 2));
    busy_lo[i] = k + 1;
    busy_hi[i] = k + np * per + 1;
    idle_at[i] = k + np * per + 2;
  endtask

  // Reset in cycle k: anything due after k never happens
  task automatic abort_run(input int i, input int k);
    for (int kd = 0; kd < 4; kd++)
      while (evq[i][kd].size() > 0 && evq[i][kd][evq[i][kd].size() - 1].cyc > k)
        void'(evq[i][kd].pop_back());
    if (busy_hi[i] > k) busy_hi[i] = k;
    idle_at[i] = k + 1;
  endtask

  task automatic check_kind(input int i, input int kd, input string nm, input logic present,
                            input logic [AW-1:0] got);
    ev_t e;
    while (evq[i][kd].size() > 0 && evq[i][kd][0].cyc < cyc) begin
      e = evq[i][kd].pop_front();
      total++;
      fail({nm, "_missing"}, i, cyc, 0, e.cyc, int'(e.val));
    end
    if (present === 1'b1) begin
      total++;
      if (evq[i][kd].size() == 0) begin
        fail({nm, "_unexpected"}, i, cyc, int'(got), -1, 0);
      end else begin
        e = evq[i][kd].pop_front();
        if (e.cyc != cyc || e.val !== got) fail(nm, i, cyc, int'(got), e.cyc, int'(e.val));
      end
    end
  endtask

  // Monitor: compare this cycle's outputs, then feed this cycle's stimulus to the model
  always @(negedge clk) begin
    obs_t o;
    logic exp_busy;
    for (int i = 0; i < NI; i++) begin
      o = obs[i];
      if (rst_prev) begin
        total++;
        if (o !== '0) fail("reset_zero", i, cyc, int'(o), cyc, 0);
      end
      check_kind(i, K_RD, "rd", o.rd_en, o.rd_addr);
      check_kind(i, K_AR, "arr", o.arr_valid,
                 {3'b000, o.row_start, o.row_finish, o.first_pass, o.pass_thru});
      if (o.arr_valid !== 1'b1) begin
        total++;
        if ({o.row_start, o.row_finish, o.first_pass, o.pass_thru} !== 4'b0000)
          fail("idle_flags", i, cyc, int'({o.row_start, o.row_finish, o.first_pass, o.pass_thru}), cyc, 0);
      end
      check_kind(i, K_WR, "wr", o.wr_en, o.wr_addr);
      check_kind(i, K_DN, "done", o.done, {6'b000000, o.result_bank});
      exp_busy = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
      total++;
      if (o.busy !== exp_busy) fail("busy", i, cyc, int'(o.busy), cyc, int'(exp_busy));
      if (rst === 1'b1) abort_run(i, cyc);
      else if (go === 1'b1 && cyc >= idle_at[i]) schedule_run(i, cyc);
    end
    rst_prev = rst;
    cyc++;
    if (finish_req) begin
      for (int i = 0; i < NI; i++)
        for (int kd = 0; kd < 4; kd++)
          if (evq[i][kd].size() > 0) begin
            total++;
            fail("leftover", i, cyc, evq[i][kd].size(), evq[i][kd][0].cyc, 0);
          end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    // one clean run
    go = 1'b1; tick(1); go = 1'b0;
    tick(150);
    // go held high: ignored while busy, restarts as soon as IDLE is back
    go = 1'b1; tick(300); go = 1'b0;
    tick(150);
    // abort in the middle of pass 1, then restart immediately
    go = 1'b1; tick(1); go = 1'b0;
    tick(90);
    rst = 1'b1; tick(1); rst = 1'b0;
    go = 1'b1; tick(1); go = 1'b0;
    tick(150);
    // random go pulses with occasional resets
    for (int n = 0; n < 8; n++) begin
      tick($urandom_range(1, 40));
      go = 1'b1; tick($urandom_range(1, 3)); go = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(1, 130));
        rst = 1'b1; tick(1); rst = 1'b0;
      end
      tick($urandom_range(0, 160));
    end
    go = 1'b0;
    tick(200);
    finish_req = 1'b1;
    tick(10);
    $display("FAIL watchdog: monitor never reached its summary");
    $fatal(1, "monitor stalled");
  end
endmodule

// File: doc/gauss_pass_sequencer.md
Name: gauss_pass_sequencer

Overview:
- Sequences a linear systolic chain of DEPTH GF(2^m) elimination cells through a full Gaussian-elimination run over an N_R x N_C matrix.
- The matrix lives in an external ping-pong RAM with two banks.
- Each pass reads every row column-serially from one bank and streams it into the chain, together with the per-word control flags the cells need. It writes the chain output into the other bank.
- Passes repeat until all rows have been through the chain: NUM_PASS = ceil(N_R/DEPTH).

Parameters:
- N_R, 8, number of matrix rows.
- N_C, 8, number of columns (words per row).
- DEPTH, 4, number of cells in the chain; rows eliminated per pass.
- RD_LAT, 1, RAM read latency in cycles (rd_en to data at the chain input).
- PIPE_LAT, 4, chain latency in cycles (chain input word to chain output word).
- Local parameters: RW=clog2(N_R), CW=clog2(N_C), AW=1+RW+CW, NUM_PASS=ceil(N_R/DEPTH).

Ports:
- clk, input, 1, system clock; single clock domain.
- rst, input, 1, synchronous active-high reset.
- go, input, 1, start pulse; sampled only in IDLE.
- busy, output, 1, high from the cycle after go is accepted until done.
- done, output, 1, one-cycle pulse when the final pass has fully drained.
- result_bank, output, 1, bank holding the final matrix; valid when done is high and held until the next go.
- rd_en, output, 1, RAM read strobe.
- rd_addr, output, AW, read address {bank, row, col}.
- arr_valid, output, 1, the word at the chain input is valid (rd_en delayed by RD_LAT).
- row_start, output, 1, chain input word is col 0 of a row.
- row_finish, output, 1, chain input word is col N_C-1 of a row.
- first_pass, output, 1, the current pass is pass 0.
- pass_thru, output, 1, current row < p*DEPTH, so the cells forward it unchanged.
- wr_en, output, 1, RAM write strobe for the chain output word.
- wr_addr, output, AW, write address {~read bank, row, col}.

Behaviour:
- Reset: state=IDLE, p=0, read bank=0, row/col counters=0, result_bank=0.
- Reset: every output is 0, and all delay lines are cleared.
- rst mid-run aborts immediately. No write strobe may appear after rst, even if one was in flight.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - go=1 -> RUN.
  - On entry to RUN: p=0, read bank=0, row=col=0.
  - go in any other state is ignored.
- RUN:
  - Every cycle: rd_en=1, rd_addr={bank,row,col}.
  - col increments; on col=N_C-1, col wraps to 0 and row increments.
  - After issuing (row=N_R-1, col=N_C-1) -> DRAIN.
  - No bubbles: exactly N_R*N_C consecutive reads per pass.
- Control alignment:
  - arr_valid, row_start, row_finish, first_pass and pass_thru are the RUN-cycle values delayed by exactly RD_LAT registers.
  - They therefore appear in the same cycle as the RAM data.
  - All of them are 0 whenever arr_valid=0.
- Write path:
  - wr_en is arr_valid delayed by exactly PIPE_LAT cycles.
  - wr_addr is the read address delayed by RD_LAT+PIPE_LAT, with the bank bit inverted.
  - Net effect: each output word lands in the same (row,col) of the other bank.
- DRAIN:
  - rd_en=0.
  - Wait until the last write of the pass has been issued, i.e. (RD_LAT+PIPE_LAT) cycles after the last read.
  - Then, if p<NUM_PASS-1: p++, bank toggles, row=col=0 -> RUN on the next cycle.
  - Otherwise -> DONE.
  - Reads of the next pass never overlap writes of the current pass.
- DONE:
  - done=1 for one cycle, and result_bank = the bank written last.
  - busy drops in the same cycle -> IDLE.
- pass_thru boundary: with N_R not a multiple of DEPTH, the last pass holds fewer than DEPTH non-bypassed rows. The count does not change; every pass still streams all N_R rows.
- Per-pass cycle count: RUN N_R*N_C cycles + DRAIN RD_LAT+PIPE_LAT cycles.

Test Plan:
- Reset then go with defaults (8x8, DEPTH=4, RD_LAT=1, PIPE_LAT=4):
  - 2 passes, 64 reads each.
  - done arrives 2*(64+5)+2 cycles after go.
  - result_bank=0.
- Alignment: check every arr_valid cycle.
  - row_start is high exactly when the delayed col=0.
  - row_finish is high exactly when the delayed col=7.
  - wr_en occurs exactly 4 cycles after arr_valid.
  - wr_addr equals rd_addr with the bank bit flipped.
- pass_thru:
  - Pass 0: always 0.
  - Pass 1: 1 for rows 0-3 (32 words), 0 for rows 4-7.
  - first_pass is 1 only in pass 0.
- N_R=6, DEPTH=4:
  - 2 passes; pass 1 bypasses rows 0-3 only.
  - Final result_bank=0.
  - Bank toggles between passes; no rd_en overlaps wr_en across a pass boundary.
- rst asserted mid-RUN of pass 1:
  - Next cycle: all outputs 0, no further wr_en.
  - A following go restarts at p=0, bank 0.
- go held high during RUN/DRAIN/DONE has no effect; a go in the cycle after done starts a new run.
